// File: rtl/serial_bus_master_p.sv
// serial_bus_master_p
// Serial bus master. It captures a user request on the rising edge of enable and asks the
// arbiter for the bus. It then shifts out the slave-select bits of the address and checks
// that both the bus and the slave accept. Once accepted, it streams the rest of the address
// followed by either the write data or a serially received read word, MSB first.
// A refused select is retried up to MAX_RETRY times. A read whose slave never answers is
// aborted after SLV_TIMEOUT cycles. Each transaction ends with a one-cycle done pulse, and
// error is raised alongside done when the transaction was aborted.
//
// Ports
//   clock, reset        system clock; synchronous active-high reset
//   enable              request strobe, rising edge starts one transaction
//   read_en             1 = read, 0 = write (captured with the enable edge)
//   data_in, addr_in    write data and target address (captured with the enable edge)
//   bus_ready           arbiter grant
//   slave_ready         selected slave accepts the transaction
//   slave_valid         slave is presenting read data on data_rx
//   data_rx             serial read data
//   bus_req             bus request to the arbiter
//   addr_tx, data_tx    serial address / write data
//   valid_s             frame valid to the slave
//   write_en_slave      inverse of captured read_en, held for the transaction
//   master_busy         transaction in progress
//   data_read           last successfully read word
//   done, error         end-of-transaction pulse and abort flag
module serial_bus_master_p #(
    parameter int ADDR_W      = 14,
    parameter int DATA_W      = 8,
    parameter int DEV_BITS    = 2,
    parameter int SLV_TIMEOUT = 16,
    parameter int MAX_RETRY   = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              read_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              bus_ready,
    input  logic              slave_ready,
    input  logic              slave_valid,
    input  logic              data_rx,
    output logic              bus_req,
    output logic              addr_tx,
    output logic              data_tx,
    output logic              valid_s,
    output logic              write_en_slave,
    output logic              master_busy,
    output logic [DATA_W-1:0] data_read,
    output logic              done,
    output logic              error
);

    localparam int CNT_W = $clog2(((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1);
    localparam int TMO_W = $clog2(SLV_TIMEOUT + 1);
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] SEL_LAST  = CNT_W'(DEV_BITS);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - DEV_BITS);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(DATA_W - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(SLV_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);

    typedef enum logic [3:0] {
        IDLE, REQ, SEL, CHK, SPLIT, ADDR, WDATA, RWAIT, RDATA, DONE
    } state_t;

    state_t            state;
    logic              enable_q;
    logic              rd_cap;
    logic [ADDR_W-1:0] addr_cap;
    logic [ADDR_W-1:0] addr_sh;
    logic [DATA_W-1:0] data_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [DATA_W-1:0] rx_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [RTY_W-1:0]  retry_cnt;

    // Read word with the current data_rx bit appended at the LSB
    assign rx_next = (rx_sh << 1) | DATA_W'(data_rx);

    // Single registered FSM. Every output is assigned on the transition into the state
    // that owns it, so the outputs seen in a cycle always belong to the current state.
    // REQ and SPLIT share the entry into SEL: a retry reloads the select bits from the
    // captured address, so the slave sees the full select phase again.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            enable_q       <= 1'b0;
            rd_cap         <= 1'b0;
            addr_cap       <= '0;
            addr_sh        <= '0;
            data_sh        <= '0;
            rx_sh          <= '0;
            bit_cnt        <= '0;
            tmo_cnt        <= '0;
            retry_cnt      <= '0;
            bus_req        <= 1'b0;
            addr_tx        <= 1'b0;
            data_tx        <= 1'b0;
            valid_s        <= 1'b0;
            write_en_slave <= 1'b0;
            master_busy    <= 1'b0;
            data_read      <= '0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            enable_q <= enable;
            done     <= 1'b0;
            error    <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && !enable_q) begin
                        addr_cap       <= addr_in;
                        data_sh        <= data_in;
                        rd_cap         <= read_en;
                        write_en_slave <= ~read_en;
                        bus_req        <= 1'b1;
                        master_busy    <= 1'b1;
                        retry_cnt      <= '0;
                        state          <= REQ;
                    end
                end
                REQ, SPLIT: begin
                    if (bus_ready) begin
                        valid_s <= 1'b1;
                        addr_tx <= addr_cap[ADDR_W-1];
                        addr_sh <= addr_cap << 1;
                        bit_cnt <= CNT_W'(1);
                        state   <= SEL;
                    end
                end
                SEL: begin
                    if (bit_cnt == SEL_LAST) begin
                        state <= CHK;
                    end else begin
                        addr_tx <= addr_sh[ADDR_W-1];
                        addr_sh <= addr_sh << 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                CHK: begin
                    if (bus_ready && slave_ready) begin
                        addr_tx <= addr_sh[ADDR_W-1];
                        addr_sh <= addr_sh << 1;
                        bit_cnt <= CNT_W'(1);
                        state   <= ADDR;
                    end else if (retry_cnt == RTY_MAX) begin
                        bus_req     <= 1'b0;
                        valid_s     <= 1'b0;
                        master_busy <= 1'b0;
                        addr_tx     <= 1'b0;
                        data_tx     <= 1'b0;
                        done        <= 1'b1;
                        error       <= 1'b1;
                        state       <= DONE;
                    end else begin
                        retry_cnt <= retry_cnt + 1'b1;
                        valid_s   <= 1'b0;
                        addr_tx   <= 1'b0;
                        state     <= SPLIT;
                    end
                end
                ADDR: begin
                    if (bit_cnt == ADDR_LAST) begin
                        addr_tx <= 1'b0;
                        if (rd_cap) begin
                            valid_s <= 1'b0;
                            tmo_cnt <= '0;
                            rx_sh   <= '0;
                            state   <= RWAIT;
                        end else begin
                            data_tx <= data_sh[DATA_W-1];
                            data_sh <= data_sh << 1;
                            bit_cnt <= CNT_W'(1);
                            state   <= WDATA;
                        end
                    end else begin
                        addr_tx <= addr_sh[ADDR_W-1];
                        addr_sh <= addr_sh << 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                WDATA: begin
                    if (bit_cnt == DATA_LAST) begin
                        bus_req     <= 1'b0;
                        valid_s     <= 1'b0;
                        master_busy <= 1'b0;
                        data_tx     <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        data_tx <= data_sh[DATA_W-1];
                        data_sh <= data_sh << 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                // slave_valid is checked before the timeout so an answer in the last
                // allowed cycle still completes the read
                RWAIT: begin
                    if (slave_valid) begin
                        if (DATA_W == 1) begin
                            data_read   <= rx_next;
                            bus_req     <= 1'b0;
                            master_busy <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            rx_sh   <= rx_next;
                            bit_cnt <= CNT_W'(1);
                            state   <= RDATA;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        bus_req     <= 1'b0;
                        master_busy <= 1'b0;
                        done        <= 1'b1;
                        error       <= 1'b1;
                        state       <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RDATA: begin
                    if (bit_cnt == RX_LAST) begin
                        data_read   <= rx_next;
                        bus_req     <= 1'b0;
                        master_busy <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        rx_sh   <= rx_next;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DONE: begin
                    write_en_slave <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bus_master_p.sv
// tb_serial_bus_master_p
// Directed bench for serial_bus_master_p with default parameters. For each transaction, a
// reference model pushes the expected per-cycle output vector into a scoreboard queue. The
// vector covers bus_req, valid_s, addr_tx, data_tx, write_en_slave, master_busy, done, error
// and data_read, starting with the first bus_req cycle and ending with the idle cycle after
// done. The queue is then popped and compared once per clock cycle.
module tb_serial_bus_master_p;

    localparam int AW  = 14;
    localparam int DW  = 8;
    localparam int DEV = 2;
    localparam int TMO = 16;
    localparam int MR  = 3;

    typedef logic [15:0] obs_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          read_en;
    logic [DW-1:0] data_in;
    logic [AW-1:0] addr_in;
    logic          bus_ready;
    logic          slave_ready;
    logic          slave_valid;
    logic          data_rx;
    logic          bus_req;
    logic          addr_tx;
    logic          data_tx;
    logic          valid_s;
    logic          write_en_slave;
    logic          master_busy;
    logic [DW-1:0] data_read;
    logic          done;
    logic          error;

    obs_t          obs;
    obs_t          exp_q[$];
    logic [DW-1:0] dr_model;
    int            total = 0;
    int            bad   = 0;

    serial_bus_master_p dut (
        .clock(clock), .reset(reset), .enable(enable), .read_en(read_en),
        .data_in(data_in), .addr_in(addr_in), .bus_ready(bus_ready),
        .slave_ready(slave_ready), .slave_valid(slave_valid), .data_rx(data_rx),
        .bus_req(bus_req), .addr_tx(addr_tx), .data_tx(data_tx), .valid_s(valid_s),
        .write_en_slave(write_en_slave), .master_busy(master_busy),
        .data_read(data_read), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    assign obs = {bus_req, valid_s, addr_tx, data_tx, write_en_slave, master_busy,
                  done, error, data_read};

    // Packs one expected output vector in the same field order as obs
    function automatic obs_t pk(input logic br, input logic vs, input logic at,
                                input logic dt, input logic we, input logic mb,
                                input logic dn, input logic er, input logic [DW-1:0] dr);
        return {br, vs, at, dt, we, mb, dn, er, dr};
    endfunction

    // Single comparison point: counts it and reports a failure with both values
    task automatic checkOutput(input string tag, input obs_t got, input obs_t want);
        total++;
        assert (got === want)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    // Reference model: expected cycle-by-cycle trace of one transaction. The trace runs
    // from REQ through the select/check attempts (with nfail refused checks), the address,
    // then the write data or the read wait and receive, the done cycle and one idle cycle.
    // delay < 0 means the slave never answers a read.
    task automatic build_expected(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                  input bit rd, input int nfail, input int delay,
                                  input logic [DW-1:0] rx);
        logic we;
        bit   aborted;
        we      = !rd;
        aborted = 1'b0;
        exp_q.push_back(pk(1, 0, 0, 0, we, 1, 0, 0, dr_model));
        for (int k = 0; k <= nfail && k <= MR; k++) begin
            for (int i = 0; i < DEV; i++)
                exp_q.push_back(pk(1, 1, a[AW-1-i], 0, we, 1, 0, 0, dr_model));
            exp_q.push_back(pk(1, 1, a[AW-DEV], 0, we, 1, 0, 0, dr_model));
            if (k < nfail) begin
                if (k == MR) aborted = 1'b1;
                else exp_q.push_back(pk(1, 0, 0, 0, we, 1, 0, 0, dr_model));
            end
        end
        if (aborted) begin
            exp_q.push_back(pk(0, 0, 0, 0, we, 0, 1, 1, dr_model));
        end else begin
            for (int i = AW - DEV - 1; i >= 0; i--)
                exp_q.push_back(pk(1, 1, a[i], 0, we, 1, 0, 0, dr_model));
            if (!rd) begin
                for (int i = DW - 1; i >= 0; i--)
                    exp_q.push_back(pk(1, 1, 0, d[i], we, 1, 0, 0, dr_model));
                exp_q.push_back(pk(0, 0, 0, 0, we, 0, 1, 0, dr_model));
            end else if (delay < 0) begin
                for (int i = 0; i < TMO; i++)
                    exp_q.push_back(pk(1, 0, 0, 0, we, 1, 0, 0, dr_model));
                exp_q.push_back(pk(0, 0, 0, 0, we, 0, 1, 1, dr_model));
            end else begin
                for (int i = 0; i < delay + DW; i++)
                    exp_q.push_back(pk(1, 0, 0, 0, we, 1, 0, 0, dr_model));
                dr_model = rx;
                exp_q.push_back(pk(0, 0, 0, 0, we, 0, 1, 0, dr_model));
            end
        end
        exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 0, 0, dr_model));
    endtask

    // Starts one transaction and plays it out cycle by cycle. It drives bus_ready or
    // slave_ready low in the refused check cycles and drives slave_valid/data_rx in the
    // read window. Each cycle it pops the next expected vector and compares it. When
    // reset_at >= 0, reset is applied after that cycle and the all-zero state is checked.
    task automatic applyStimulus(input string tag, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input bit rd, input int nfail,
                                 input bit fail_slave, input int delay,
                                 input logic [DW-1:0] rx, input int reset_at);
        obs_t e;
        int   idx;
        int   r0;
        int   j;
        enable = 1'b0;
        @(posedge clock); #1;
        addr_in = a; data_in = d; read_en = rd;
        bus_ready = 1'b1; slave_ready = 1'b1; slave_valid = 1'b0; data_rx = 1'b0;
        build_expected(a, d, rd, nfail, delay, rx);
        enable = 1'b1;
        r0  = 1 + nfail * (DEV + 2) + DEV + 1 + (AW - DEV);
        idx = 0;
        @(posedge clock); #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput($sformatf("%s[%0d]", tag, idx), obs, e);
            if (idx == reset_at) begin
                exp_q.delete();
                reset = 1'b1; enable = 1'b0;
                @(posedge clock); #1;
                checkOutput({tag, "_reset"}, obs, '0);
                reset = 1'b0;
                dr_model = '0;
            end else begin
                bus_ready = 1'b1; slave_ready = 1'b1;
                for (int k = 0; k < nfail; k++) begin
                    if (idx == 1 + DEV + k * (DEV + 2)) begin
                        if (fail_slave) slave_ready = 1'b0;
                        else bus_ready = 1'b0;
                    end
                end
                j = idx - r0 - delay;
                if (delay >= 0 && j >= 0 && j < DW) begin
                    slave_valid = 1'b1;
                    data_rx     = rx[DW-1-j];
                end else begin
                    slave_valid = 1'b0;
                    data_rx     = 1'b0;
                end
                @(posedge clock); #1;
                idx++;
            end
        end
        slave_valid = 1'b0;
        data_rx     = 1'b0;
    endtask

    // Directed sequence: reset state, plain write, read, split retry, retry abort,
    // read timeout, reset mid-write, and read latency boundaries
    initial begin
        reset = 1'b1; enable = 1'b0; read_en = 1'b0; data_in = '0; addr_in = '0;
        bus_ready = 1'b0; slave_ready = 1'b0; slave_valid = 1'b0; data_rx = 1'b0;
        dr_model = '0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_state", obs, '0);
        reset = 1'b0;

        $display("[TB] write 0x2A5C/0xB7 with enable held high");
        applyStimulus("wr", 14'h2A5C, 8'hB7, 1'b0, 0, 1'b0, 0, 8'h00, -1);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("held_en[%0d]", i), {14'b0, bus_req, master_busy}, '0);
            @(posedge clock); #1;
        end

        $display("[TB] read 0x0123, slave answers after 3 cycles");
        applyStimulus("rd", 14'h0123, 8'h00, 1'b1, 0, 1'b0, 3, 8'hC3, -1);

        $display("[TB] write with one slave refusal");
        applyStimulus("split", 14'h1F0F, 8'h5A, 1'b0, 1, 1'b1, 0, 8'h00, -1);

        $display("[TB] read with bus refused in every check");
        applyStimulus("abort", 14'h3A55, 8'h00, 1'b1, 4, 1'b0, 0, 8'h00, -1);

        $display("[TB] read with silent slave");
        applyStimulus("tmo", 14'h0ACE, 8'h00, 1'b1, 0, 1'b0, -1, 8'h00, -1);

        $display("[TB] reset during write data");
        applyStimulus("rstwr", 14'h2222, 8'hF0, 1'b0, 0, 1'b0, 0, 8'h00, 18);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("post_reset[%0d]", i), obs, '0);
            @(posedge clock); #1;
        end

        $display("[TB] read latency boundaries");
        applyStimulus("rd_fast", 14'h0000, 8'h00, 1'b1, 0, 1'b0, 0, 8'h81, -1);
        applyStimulus("rd_last", 14'h3FFF, 8'h00, 1'b1, 0, 1'b0, TMO - 1, 8'h3C, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
